// File: rtl/hazard_forward_unit.sv
// Load-use / flush / freeze hazard controller for the 5-stage core.
// Also registers the ALU forwarding selects for the instruction entering EX.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  branch_taken,
  input  logic                  ext_stall,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic [PERF_W-1:0]     load_use_stalls
);

  // Only EX and MEM producers matter: a producer already in WB while the
  // consumer sits in ID is covered by the write-first register file.
  logic [REG_ADDR_W-1:0] ex_rd_reg;
  logic                  ex_we_reg;
  logic                  ex_load_reg;
  logic [REG_ADDR_W-1:0] mem_rd_reg;
  logic                  mem_we_reg;

  logic [REG_ADDR_W-1:0] src      [2];
  logic                  use_src  [2];
  logic [1:0]            sel_next [2];
  logic                  lu_hit   [2];

  logic load_use;
  logic take_bubble;
  logic accept_lu;

  assign src[0]     = id_rs1;
  assign src[1]     = id_rs2;
  assign use_src[0] = id_uses_rs1;
  assign use_src[1] = id_uses_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic live;
      logic match_ex;
      logic match_mem;

      assign live      = id_valid & use_src[gi] & (src[gi] != '0);
      assign match_ex  = live & ex_we_reg  & (ex_rd_reg  == src[gi]);
      assign match_mem = live & mem_we_reg & (mem_rd_reg == src[gi]);
      assign sel_next[gi] = match_ex  ? 2'b10 :
                            match_mem ? 2'b01 : 2'b00;
      assign lu_hit[gi] = match_ex & ex_load_reg;
    end
  endgenerate

  assign load_use    = lu_hit[0] | lu_hit[1];
  assign take_bubble = branch_taken | load_use;
  assign accept_lu   = load_use & ~branch_taken;

  // A frozen pipeline needs neither a stall nor a bubble; reset masks both.
  assign stall_if_id = rst_n & ~ext_stall & accept_lu;
  assign bubble_ex   = rst_n & ~ext_stall & take_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_reg       <= '0;
      ex_we_reg       <= 1'b0;
      ex_load_reg     <= 1'b0;
      mem_rd_reg      <= '0;
      mem_we_reg      <= 1'b0;
      forwardA        <= 2'b00;
      forwardB        <= 2'b00;
      load_use_stalls <= '0;
    end else if (!ext_stall) begin
      mem_rd_reg <= ex_rd_reg;
      mem_we_reg <= ex_we_reg;
      if (take_bubble) begin
        ex_rd_reg   <= '0;
        ex_we_reg   <= 1'b0;
        ex_load_reg <= 1'b0;
        forwardA    <= 2'b00;
        forwardB    <= 2'b00;
      end else begin
        ex_rd_reg   <= id_rd;
        ex_we_reg   <= id_valid & id_regwrite;
        ex_load_reg <= id_valid & id_memread;
        forwardA    <= sel_next[0];
        forwardB    <= sel_next[1];
      end
      if (accept_lu) begin
        load_use_stalls <= load_use_stalls + 1'b1;
      end
    end
  end

endmodule
